// File: rtl/serial_buffer.sv
// rtl/serial_buffer.sv - TX/RX byte FIFO pair between the data memory stage and an external serial link
// Optional sticky overflow flags are enabled with the SERIAL_BUFFER_OVERFLOW_EN macro.

module serial_buffer_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_req,
    input  logic [7:0] push_data,
    input  logic       pop_req,
`ifdef SERIAL_BUFFER_OVERFLOW_EN
    input  logic       overflow_clr,
    output logic       overflow,
`endif
    output logic [7:0] head,
    output logic       not_empty,
    output logic       not_full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Flags come from the registered count, so a pop on a full FIFO cannot make room for the same-cycle push.
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign push      = push_req && !full;
    assign pop       = pop_req && !empty;
    assign not_empty = !empty;
    assign not_full  = !full;
    assign head      = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef SERIAL_BUFFER_OVERFLOW_EN
    // A drop in the same cycle as a clear wins, so no overflow event is ever lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (push_req && full) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end
`endif

endmodule

module serial_buffer #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cpu_wdata_in,
    input  logic       cpu_wren_in,
    input  logic       cpu_rden_in,
    output logic [7:0] cpu_rdata_out,
    output logic       cpu_rx_valid_out,
    output logic       cpu_tx_ready_out,
    output logic [7:0] tx_data_out,
    output logic       tx_valid_out,
    input  logic       tx_ready_in,
    input  logic [7:0] rx_data_in,
    input  logic       rx_valid_in,
`ifdef SERIAL_BUFFER_OVERFLOW_EN
    output logic       tx_overflow_out,
    output logic       rx_overflow_out,
    input  logic       overflow_clr_in,
`endif
    output logic       rx_ready_out
);

    serial_buffer_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_req     (cpu_wren_in),
        .push_data    (cpu_wdata_in),
        .pop_req      (tx_ready_in),
`ifdef SERIAL_BUFFER_OVERFLOW_EN
        .overflow_clr (overflow_clr_in),
        .overflow     (tx_overflow_out),
`endif
        .head         (tx_data_out),
        .not_empty    (tx_valid_out),
        .not_full     (cpu_tx_ready_out)
    );

    serial_buffer_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_req     (rx_valid_in),
        .push_data    (rx_data_in),
        .pop_req      (cpu_rden_in),
`ifdef SERIAL_BUFFER_OVERFLOW_EN
        .overflow_clr (overflow_clr_in),
        .overflow     (rx_overflow_out),
`endif
        .head         (cpu_rdata_out),
        .not_empty    (cpu_rx_valid_out),
        .not_full     (rx_ready_out)
    );

endmodule

// File: tb/tb_serial_buffer.sv
// tb/tb_serial_buffer.sv - self-checking bench for serial_buffer (vector table, directed corners, random vs queue model)

module tb_serial_buffer;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cpu_wdata_in;
    logic       cpu_wren_in;
    logic       cpu_rden_in;
    logic [7:0] cpu_rdata_out;
    logic       cpu_rx_valid_out;
    logic       cpu_tx_ready_out;
    logic [7:0] tx_data_out;
    logic       tx_valid_out;
    logic       tx_ready_in;
    logic [7:0] rx_data_in;
    logic       rx_valid_in;
    logic       rx_ready_out;
    logic       overflow_clr;
`ifdef SERIAL_BUFFER_OVERFLOW_EN
    logic       tx_overflow_out;
    logic       rx_overflow_out;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       m_tx_ovf;
    logic       m_rx_ovf;

    typedef struct packed {
        logic       wren;
        logic [7:0] wdata;
        logic       txr;
        logic       rden;
        logic       rxv;
        logic [7:0] rxd;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[10];

    localparam logic [19:0] IDLE_OUT = {1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};

    always #5 clk = ~clk;

    serial_buffer #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .cpu_wdata_in     (cpu_wdata_in),
        .cpu_wren_in      (cpu_wren_in),
        .cpu_rden_in      (cpu_rden_in),
        .cpu_rdata_out    (cpu_rdata_out),
        .cpu_rx_valid_out (cpu_rx_valid_out),
        .cpu_tx_ready_out (cpu_tx_ready_out),
        .tx_data_out      (tx_data_out),
        .tx_valid_out     (tx_valid_out),
        .tx_ready_in      (tx_ready_in),
        .rx_data_in       (rx_data_in),
        .rx_valid_in      (rx_valid_in),
`ifdef SERIAL_BUFFER_OVERFLOW_EN
        .tx_overflow_out  (tx_overflow_out),
        .rx_overflow_out  (rx_overflow_out),
        .overflow_clr_in  (overflow_clr),
`endif
        .rx_ready_out     (rx_ready_out)
    );

    function automatic logic [19:0] dut_out();
        return {tx_valid_out, tx_data_out, cpu_tx_ready_out, cpu_rx_valid_out, cpu_rdata_out, rx_ready_out};
    endfunction

    function automatic logic [19:0] model_out();
        logic [7:0] th;
        logic [7:0] rh;
        th = 8'h00;
        rh = 8'h00;
        if (tx_q.size() != 0) th = tx_q[0];
        if (rx_q.size() != 0) rh = rx_q[0];
        return {tx_q.size() != 0, th, tx_q.size() < DEPTH, rx_q.size() != 0, rh, rx_q.size() < DEPTH};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance the queue model, then compare after the edge.
    task automatic drive_cycle(input logic w, input logic [7:0] wd, input logic tr, input logic rd,
                               input logic rv, input logic [7:0] rdat, input logic clr);
        bit tx_full, rx_full, tx_pop, rx_pop;
        cpu_wren_in  = w;
        cpu_wdata_in = wd;
        tx_ready_in  = tr;
        cpu_rden_in  = rd;
        rx_valid_in  = rv;
        rx_data_in   = rdat;
        overflow_clr = clr;
        tx_full = (tx_q.size() == DEPTH);
        rx_full = (rx_q.size() == DEPTH);
        tx_pop  = tr && tx_q.size() != 0;
        rx_pop  = rd && rx_q.size() != 0;
        if (w && tx_full) m_tx_ovf = 1'b1;
        else if (clr) m_tx_ovf = 1'b0;
        if (rv && rx_full) m_rx_ovf = 1'b1;
        else if (clr) m_rx_ovf = 1'b0;
        if (tx_pop) void'(tx_q.pop_front());
        if (rx_pop) void'(rx_q.pop_front());
        if (w && !tx_full) tx_q.push_back(wd);
        if (rv && !rx_full) rx_q.push_back(rdat);
        @(posedge clk);
        #1;
        check("model", {12'h0, dut_out()}, {12'h0, model_out()});
`ifdef SERIAL_BUFFER_OVERFLOW_EN
        check("model_ovf", {30'h0, tx_overflow_out, rx_overflow_out}, {30'h0, m_tx_ovf, m_rx_ovf});
`endif
    endtask

    task automatic idle();
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, {1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1}};
        tbl[1] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, {1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1}};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, {1'b1, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1}};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, {1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1}};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, {1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b1}};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h22, {1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b1}};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, {1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1}};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, {1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1}};
        tbl[8] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, {1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1}};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, {1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1}};

        reset        = 1'b0;
        cpu_wdata_in = 8'h00;
        cpu_wren_in  = 1'b0;
        cpu_rden_in  = 1'b0;
        tx_ready_in  = 1'b0;
        rx_data_in   = 8'h00;
        rx_valid_in  = 1'b0;
        overflow_clr = 1'b0;
        m_tx_ovf     = 1'b0;
        m_rx_ovf     = 1'b0;
        #1;
        check("reset_async", {12'h0, dut_out()}, {12'h0, IDLE_OUT});
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", {12'h0, dut_out()}, {12'h0, IDLE_OUT});
`ifdef SERIAL_BUFFER_OVERFLOW_EN
        check("reset_ovf", {30'h0, tx_overflow_out, rx_overflow_out}, 32'h0);
`endif
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive_cycle(tbl[i].wren, tbl[i].wdata, tbl[i].txr, tbl[i].rden, tbl[i].rxv, tbl[i].rxd, 1'b0);
            check($sformatf("vec%0d", i), {12'h0, dut_out()}, {12'h0, tbl[i].exp});
        end

        // TX overflow: ninth write dropped, drain returns the first eight in order
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("tx_full_ready", {31'h0, cpu_tx_ready_out}, 32'h0);
        drive_cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
`ifdef SERIAL_BUFFER_OVERFLOW_EN
        check("tx_ovf_set", {31'h0, tx_overflow_out}, 32'h1);
`endif
        for (int i = 0; i < DEPTH; i++) begin
            check("tx_drain", {24'h0, tx_data_out}, {24'h0, 8'(8'h40 + i)});
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        check("tx_drained", {31'h0, tx_valid_out}, 32'h0);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
`ifdef SERIAL_BUFFER_OVERFLOW_EN
        check("tx_ovf_clr", {31'h0, tx_overflow_out}, 32'h0);
`endif

        // RX fill to full, drop one, drain in order
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'(8'h11 + i), 1'b0);
        check("rx_full_ready", {31'h0, rx_ready_out}, 32'h0);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            check("rx_drain", {24'h0, cpu_rdata_out}, {24'h0, 8'(8'h11 + i)});
            drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        end
        check("rx_drained", {23'h0, cpu_rx_valid_out, cpu_rdata_out}, 32'h0);

        // Full TX with simultaneous push and pop: pop only, 0x77 never appears
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive_cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("full_pp_ready", {31'h0, cpu_tx_ready_out}, 32'h1);
        for (int i = 1; i < DEPTH; i++) begin
            check("full_pp_drain", {24'h0, tx_data_out}, {24'h0, 8'(8'h80 + i)});
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        check("full_pp_empty", {31'h0, tx_valid_out}, 32'h0);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Random interleaved traffic with stalls, across many pointer wraps
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                        1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
                        1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 2 * DEPTH; i++) drive_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        check("random_empty", {12'h0, dut_out()}, {12'h0, IDLE_OUT});

        // Reset mid-stream, between clock edges
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b1, 8'(8'hD0 + i), 1'b0);
        check("pre_reset", {12'h0, dut_out()}, {12'h0, 1'b1, 8'hC0, 1'b1, 1'b1, 8'hD0, 1'b1});
        #2;
        reset = 1'b0;
        #1;
        check("midstream_reset", {12'h0, dut_out()}, {12'h0, IDLE_OUT});
        tx_q.delete();
        rx_q.delete();
        m_tx_ovf = 1'b0;
        m_rx_ovf = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive_cycle(1'b1, 8'hE1, 1'b0, 1'b0, 1'b1, 8'hE2, 1'b0);
        check("post_reset", {12'h0, dut_out()}, {12'h0, 1'b1, 8'hE1, 1'b1, 1'b1, 8'hE2, 1'b1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_buffer.md
SERIAL_BUFFER -- requirements
Module: serial_buffer

Interface
REQ-001 Parameter DEPTH, default 8, entries per FIFO; power of two, 2..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cpu_wdata_in  input  8  byte written by the data memory stage (its serial_out).
REQ-005 cpu_wren_in  input  1  TX push request (its serial_wren_out).
REQ-006 cpu_rden_in  input  1  RX pop request (its serial_rden_out).
REQ-007 cpu_rdata_out  output  8  RX head byte (drives its serial_in).
REQ-008 cpu_rx_valid_out  output  1  RX FIFO non-empty (drives its serial_valid_in).
REQ-009 cpu_tx_ready_out  output  1  TX FIFO not full (drives its serial_ready_in).
REQ-010 tx_data_out  output  8  TX head byte to the external link.
REQ-011 tx_valid_out  output  1  TX FIFO non-empty.
REQ-012 tx_ready_in  input  1  external link accepts tx_data_out this cycle.
REQ-013 rx_data_in  input  8  byte from the external link.
REQ-014 rx_valid_in  input  1  rx_data_in valid this cycle.
REQ-015 rx_ready_out  output  1  RX FIFO not full.

Function
REQ-016 Two independent FIFOs (TX, RX), each DEPTH x 8, with read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH and an occupancy count of log2(DEPTH)+1 bits.
REQ-017 Full and empty flags derive only from the registered count; count == DEPTH is full, count == 0 is empty.
REQ-018 TX push occurs when cpu_wren_in=1 and TX not full; cpu_wren_in while full is dropped and the FIFO is unchanged.
REQ-019 TX pop occurs when tx_valid_out=1 and tx_ready_in=1; tx_ready_in while empty has no effect.
REQ-020 RX push occurs when rx_valid_in=1 and rx_ready_out=1; rx_valid_in while full is dropped.
REQ-021 RX pop occurs when cpu_rden_in=1 and RX not empty; cpu_rden_in while empty has no effect.
REQ-022 Both FIFOs are first-word fall-through: a byte pushed at edge N is visible on the head output, with the valid flag high, after edge N.
REQ-023 cpu_rdata_out and tx_data_out show the head entry when non-empty and 8'h00 when empty.
REQ-024 Simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged and advances both pointers.
REQ-025 Simultaneous push and pop on a full FIFO: pop is performed, push is dropped (full is evaluated before the edge); count becomes DEPTH-1.
REQ-026 Simultaneous push and pop on an empty FIFO: push only; count becomes 1.
REQ-027 Byte order is preserved across pointer wrap-around.

Reset
REQ-028 Assertion of reset (low) immediately clears all pointers and counts, regardless of clk, discarding in-flight bytes.
REQ-029 During and after reset: cpu_rx_valid_out=0, tx_valid_out=0, cpu_tx_ready_out=1, rx_ready_out=1, cpu_rdata_out=8'h00, tx_data_out=8'h00.
REQ-030 Storage array contents need no reset; they are never observable while empty.

Configuration
REQ-031 Macro SERIAL_BUFFER_OVERFLOW_EN defined: adds ports tx_overflow_out (output 1), rx_overflow_out (output 1), overflow_clr_in (input 1).
REQ-032 With the macro, each overflow output is a sticky flag set on the edge after a dropped push (REQ-018/020/025) and cleared by overflow_clr_in=1 or reset; a simultaneous set and clear results in set.
REQ-033 Without the macro, those ports and flags do not exist and drops are silent; all other behaviour is identical.

Verification
REQ-034 After reset, write 8'hA5, 8'h3C with tx_ready_in=0 -> tx_valid_out=1, tx_data_out=8'hA5; raise tx_ready_in for 2 cycles -> 8'hA5 then 8'h3C, then tx_valid_out=0.
REQ-035 DEPTH=8: push 8 TX bytes with tx_ready_in=0 -> cpu_tx_ready_out=0; 9th write 8'hFF dropped; drain yields only the first 8 bytes in order (tx_overflow_out=1 with macro).
REQ-036 RX: drive rx_valid_in with 8'h11..8'h18 -> rx_ready_out=0 after 8th; cpu_rden_in pulses return 8'h11..8'h18 in order; then cpu_rx_valid_out=0, cpu_rdata_out=8'h00.
REQ-037 Full TX FIFO, same-cycle cpu_wren_in (8'h77) and tx_ready_in -> one byte out, count=7, 8'h77 absent from the drained stream.
REQ-038 20 interleaved push/pop cycles over pointer wrap with random stalls -> output stream equals input stream, no loss or duplication.
REQ-039 Assert reset mid-stream with 5 bytes in each FIFO -> all valid flags 0 and ready flags 1 immediately, with no clk edge required.
